// File: rtl/mem_port_arbiter.sv
// Shares memory port B between SPU single-beat ops and VGA read bursts (round robin + VGA urgency + SPU starvation guard).
// Latency: one decision cycle, then issue; read data steered back MEM_LAT cycles after mem_en.
// Backpressure: requesters hold req until their grant pulse; a VGA burst is never interrupted.
module mem_port_arbiter #(
    parameter int BURST_LEN  = 8,
    parameter int MEM_LAT    = 1,
    parameter int URGENT_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         spu_req,
    input  logic [15:0]  spu_we,
    input  logic [31:0]  spu_addr,
    input  logic [127:0] spu_wdata,
    output logic         spu_gnt,
    output logic         spu_rvalid,
    output logic [127:0] spu_rdata,
    input  logic         vga_req,
    input  logic         vga_urgent,
    input  logic [31:0]  vga_addr,
    output logic         vga_gnt,
    output logic         vga_rvalid,
    output logic [127:0] vga_rdata,
    output logic         vga_done,
    output logic         mem_en,
    output logic [15:0]  mem_we,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata
);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int URG_W  = (URGENT_MAX > 0) ? $clog2(URGENT_MAX + 1) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [URG_W-1:0]  URG_MAX   = URG_W'(URGENT_MAX);

    typedef enum logic [1:0] {IDLE, SPU, VGA} state_t;

    state_t              state_q, state_d;
    logic                last_vga_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [URG_W-1:0]    urg_cnt_q;
    logic                urg_win_q;
    logic [31:0]         vga_base_q;
    logic                urgent_vga;
    logic                last_beat;
    logic [MEM_LAT-1:0]  tag_rd_q, tag_vga_q, tag_last_q;

    // The starvation guard only bites when SPU is actually waiting.
    assign urgent_vga = vga_req && vga_urgent && !(spu_req && (urg_cnt_q == URG_MAX));
    assign last_beat  = (beat_q == LAST_BEAT);

    always_comb begin
        state_d   = state_q;
        spu_gnt   = 1'b0;
        vga_gnt   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (urgent_vga)              state_d = VGA;
                else if (spu_req && vga_req) state_d = last_vga_q ? SPU : VGA;
                else if (spu_req)            state_d = SPU;
                else if (vga_req)            state_d = VGA;
            end
            SPU: begin
                mem_en    = 1'b1;
                mem_we    = spu_we;
                mem_addr  = spu_addr;
                mem_wdata = spu_wdata;
                spu_gnt   = 1'b1;
                state_d   = IDLE;
            end
            VGA: begin
                mem_en   = 1'b1;
                mem_addr = vga_base_q + {{(28 - BEAT_W){1'b0}}, beat_q, 4'b0000};
                vga_gnt  = (beat_q == '0);
                if (last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_vga_q <= 1'b1;
            beat_q     <= '0;
            urg_cnt_q  <= '0;
            urg_win_q  <= 1'b0;
            vga_base_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (state_d == VGA) begin
                        vga_base_q <= vga_addr;
                        beat_q     <= '0;
                        urg_win_q  <= urgent_vga && spu_req;
                    end
                end
                SPU: begin
                    last_vga_q <= 1'b0;
                    urg_cnt_q  <= '0;
                end
                VGA: begin
                    beat_q <= beat_q + BEAT_W'(1);
                    if (last_beat) begin
                        last_vga_q <= 1'b1;
                        if (!urg_win_q)                urg_cnt_q <= '0;
                        else if (urg_cnt_q != URG_MAX) urg_cnt_q <= urg_cnt_q + URG_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Return tags travel alongside the memory's read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_rd_q   <= '0;
            tag_vga_q  <= '0;
            tag_last_q <= '0;
        end else begin
            tag_rd_q[0]   <= mem_en && (mem_we == 16'h0000);
            tag_vga_q[0]  <= (state_q == VGA);
            tag_last_q[0] <= (state_q == VGA) && last_beat;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_rd_q[i]   <= tag_rd_q[i-1];
                tag_vga_q[i]  <= tag_vga_q[i-1];
                tag_last_q[i] <= tag_last_q[i-1];
            end
        end
    end

    assign spu_rvalid = tag_rd_q[MEM_LAT-1] && !tag_vga_q[MEM_LAT-1];
    assign vga_rvalid = tag_rd_q[MEM_LAT-1] && tag_vga_q[MEM_LAT-1];
    assign vga_done   = vga_rvalid && tag_last_q[MEM_LAT-1];
    assign spu_rdata  = mem_rdata;
    assign vga_rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int BL  = 8;
    localparam int LAT = 1;
    localparam int UM  = 4;

    logic         clk, rst_n;
    logic         spu_req, vga_req, vga_urgent;
    logic [15:0]  spu_we;
    logic [31:0]  spu_addr, vga_addr;
    logic [127:0] spu_wdata;
    logic         spu_gnt, spu_rvalid, vga_gnt, vga_rvalid, vga_done, mem_en;
    logic [127:0] spu_rdata, vga_rdata, mem_wdata, mem_rdata;
    logic [15:0]  mem_we;
    logic [31:0]  mem_addr;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.BURST_LEN(BL), .MEM_LAT(LAT), .URGENT_MAX(UM)) dut (
        .clk(clk), .rst_n(rst_n),
        .spu_req(spu_req), .spu_we(spu_we), .spu_addr(spu_addr), .spu_wdata(spu_wdata),
        .spu_gnt(spu_gnt), .spu_rvalid(spu_rvalid), .spu_rdata(spu_rdata),
        .vga_req(vga_req), .vga_urgent(vga_urgent), .vga_addr(vga_addr),
        .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata), .vga_done(vga_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] fdata(input logic [31:0] a);
        return {a, ~a, a ^ 32'hA5A5_5A5A, a + 32'd1};
    endfunction

    // Memory stub: one-cycle read latency, contents derived from the address.
    always @(posedge clk) mem_rdata <= fdata(mem_addr);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        spu_req = 0; spu_we = '0; spu_addr = '0; spu_wdata = '0;
        vga_req = 0; vga_urgent = 0; vga_addr = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        spu_req = 1; spu_we = '1; spu_addr = 32'h1234; spu_wdata = '1;
        vga_req = 1; vga_urgent = 1; vga_addr = 32'h40;
        repeat (2) cyc();
        tests++;
        if ({mem_en, spu_gnt, vga_gnt, spu_rvalid, vga_rvalid, vga_done} !== 6'b0) begin
            fails++; $display("FAIL reset_strobes got %b want 000000",
                {mem_en, spu_gnt, vga_gnt, spu_rvalid, vga_rvalid, vga_done});
        end
        tests++;
        if (mem_we !== 16'h0) begin fails++; $display("FAIL reset_mem_we got %h want 0", mem_we); end
        tests++;
        if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        tests++;
        if (mem_wdata !== 128'h0) begin fails++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
        clear_inputs();
        rst_n = 1;
        cyc();
        tests++;
        if (mem_en !== 1'b0) begin fails++; $display("FAIL idle_no_req mem_en got %b want 0", mem_en); end
    endtask

    task automatic test_spu_read();
        logic [31:0] a;
        a = 32'h0080_0010;
        reset_dut();
        spu_req = 1; spu_we = 16'h0; spu_addr = a; spu_wdata = {4{$urandom}};
        cyc();
        tests++;
        if ({mem_en, spu_gnt, vga_gnt} !== 3'b110) begin
            fails++; $display("FAIL spu_issue en/sgnt/vgnt got %b want 110", {mem_en, spu_gnt, vga_gnt});
        end
        tests++;
        if (mem_addr !== a || mem_we !== 16'h0) begin
            fails++; $display("FAIL spu_issue addr/we got %h/%h want %h/0", mem_addr, mem_we, a);
        end
        spu_req = 0;
        cyc();
        tests++;
        if ({spu_rvalid, vga_rvalid, mem_en, spu_gnt} !== 4'b1000) begin
            fails++; $display("FAIL spu_return srv/vrv/en/gnt got %b want 1000",
                {spu_rvalid, vga_rvalid, mem_en, spu_gnt});
        end
        tests++;
        if (spu_rdata !== fdata(a)) begin
            fails++; $display("FAIL spu_rdata got %h want %h", spu_rdata, fdata(a));
        end
        cyc();
        tests++;
        if (spu_rvalid !== 1'b0) begin fails++; $display("FAIL spu_rvalid_single got %b want 0", spu_rvalid); end
    endtask

    task automatic test_vga_burst();
        logic [31:0] base, want_a;
        int nrv;
        base = 32'h0090_0000;
        nrv = 0;
        reset_dut();
        vga_req = 1; vga_urgent = 0; vga_addr = base;
        for (int c = 0; c < BL + 2; c++) begin
            cyc();
            if (c == 0) vga_req = 0;
            want_a = (c < BL) ? base + 32'(16 * c) : 32'h0;
            tests++;
            if (mem_en !== (c < BL) || mem_addr !== want_a || mem_we !== 16'h0) begin
                fails++; $display("FAIL vga_beat%0d en/addr/we got %b/%h/%h want %b/%h/0",
                    c, mem_en, mem_addr, mem_we, (c < BL), want_a);
            end
            tests++;
            if (vga_gnt !== (c == 0)) begin
                fails++; $display("FAIL vga_gnt_c%0d got %b want %b", c, vga_gnt, (c == 0));
            end
            tests++;
            if (vga_rvalid !== (c >= 1 && c <= BL) || vga_done !== (c == BL) || spu_rvalid !== 1'b0) begin
                fails++; $display("FAIL vga_ret_c%0d vrv/done/srv got %b/%b/%b want %b/%b/0",
                    c, vga_rvalid, vga_done, spu_rvalid, (c >= 1 && c <= BL), (c == BL));
            end
            if (vga_rvalid === 1'b1) begin
                nrv++;
                tests++;
                if (vga_rdata !== fdata(base + 32'(16 * (nrv - 1)))) begin
                    fails++; $display("FAIL vga_rdata_beat%0d got %h want %h", nrv - 1,
                        vga_rdata, fdata(base + 32'(16 * (nrv - 1))));
                end
            end
        end
        tests++;
        if (nrv != BL) begin fails++; $display("FAIL vga_beat_count got %0d want %0d", nrv, BL); end
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        want[0] = 32'hFFFF_FFF0; want[1] = 32'h0000_0000; want[2] = 32'h0000_0010;
        reset_dut();
        vga_req = 1; vga_addr = 32'hFFFF_FFF0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            vga_req = 0;
            tests++;
            if (mem_addr !== want[c]) begin
                fails++; $display("FAIL wrap_beat%0d got %h want %h", c, mem_addr, want[c]);
            end
        end
        repeat (BL) cyc();
    endtask

    task automatic test_alternate();
        int sg[$];
        int vg[$];
        logic sr_seen;
        sr_seen = 0;
        reset_dut();
        spu_req = 1; spu_we = 16'hFFFF; spu_addr = 32'h100; spu_wdata = {4{$urandom}};
        vga_req = 1; vga_urgent = 0; vga_addr = 32'h2000;
        for (int c = 1; c <= 14; c++) begin
            cyc();
            if (spu_rvalid === 1'b1) sr_seen = 1;
            if (spu_gnt === 1'b1) begin
                sg.push_back(c);
                tests++;
                if (mem_we !== 16'hFFFF || mem_wdata !== spu_wdata) begin
                    fails++; $display("FAIL alt_write_cmd we/wdata got %h/%h want ffff/%h",
                        mem_we, mem_wdata, spu_wdata);
                end
                if (sg.size() == 2) spu_req = 0;
            end
            if (vga_gnt === 1'b1) begin vg.push_back(c); vga_req = 0; end
        end
        tests++;
        if (sg.size() != 2 || sg[0] != 1 || sg[1] != 12) begin
            fails++; $display("FAIL alt_spu_gnt_cycles got n=%0d first=%0d want 2 grants at 1,12",
                sg.size(), (sg.size() > 0) ? sg[0] : -1);
        end
        tests++;
        if (vg.size() != 1 || vg[0] != 3) begin
            fails++; $display("FAIL alt_vga_gnt_cycles got n=%0d first=%0d want 1 grant at 3",
                vg.size(), (vg.size() > 0) ? vg[0] : -1);
        end
        tests++;
        if (sr_seen !== 1'b0) begin fails++; $display("FAIL write_no_rvalid got %b want 0", sr_seen); end
    endtask

    task automatic test_urgent();
        int vcnt, scnt, sfirst;
        logic vga_at_39;
        vcnt = 0; scnt = 0; sfirst = -1; vga_at_39 = 0;
        reset_dut();
        spu_req = 1; spu_addr = 32'h300;
        vga_req = 1; vga_urgent = 1; vga_addr = 32'h4000;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (spu_gnt === 1'b1) begin
                scnt++;
                if (sfirst < 0) sfirst = c;
                spu_req = 0;
            end
            if (vga_gnt === 1'b1 && sfirst < 0) vcnt++;
            if (c == 39) vga_at_39 = vga_gnt;
        end
        tests++;
        if (vcnt != UM) begin fails++; $display("FAIL urgent_vga_wins got %0d want %0d", vcnt, UM); end
        tests++;
        if (sfirst != 37 || scnt != 1) begin
            fails++; $display("FAIL urgent_spu_gnt cycle/count got %0d/%0d want 37/1", sfirst, scnt);
        end
        tests++;
        if (vga_at_39 !== 1'b1) begin fails++; $display("FAIL urgent_vga_resume got %b want 1", vga_at_39); end
        clear_inputs();
        repeat (BL + 2) cyc();
    endtask

    task automatic test_reset_mid_burst();
        int stray;
        stray = 0;
        reset_dut();
        vga_req = 1; vga_addr = 32'h0050_0000;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            vga_req = 0;
        end
        rst_n = 0;
        #1;
        tests++;
        if ({mem_en, vga_gnt, vga_rvalid, vga_done, spu_rvalid} !== 5'b0 || mem_addr !== 32'h0) begin
            fails++; $display("FAIL midburst_reset en/vg/vrv/done/srv got %b addr %h want 00000 addr 0",
                {mem_en, vga_gnt, vga_rvalid, vga_done, spu_rvalid}, mem_addr);
        end
        repeat (2) cyc();
        rst_n = 1;
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (vga_rvalid !== 1'b0 || vga_done !== 1'b0 || mem_en !== 1'b0) stray++;
        end
        tests++;
        if (stray != 0) begin fails++; $display("FAIL post_reset_stray got %0d cycles want 0", stray); end
        spu_req = 1; spu_addr = 32'h600; vga_req = 1; vga_addr = 32'h7000;
        cyc();
        tests++;
        if ({spu_gnt, vga_gnt} !== 2'b10) begin
            fails++; $display("FAIL post_reset_first_winner sgnt/vgnt got %b want 10", {spu_gnt, vga_gnt});
        end
        clear_inputs();
        repeat (BL + 2) cyc();
    endtask

    task automatic test_random();
        int busy_until = 0, start = 0, kind = 0, urg = 0, b = 0;
        bit last_vga = 1, urg_win = 0, prev_sg = 0, prev_vg = 0;
        logic [31:0] base = 0, a_s = 0;
        logic [15:0] we_s = 0;
        logic [127:0] wd_s = 0;
        int due_q[$];
        bit own_q[$];
        bit lst_q[$];
        logic [31:0] ra_q[$];
        logic e_en, e_sg, e_vg, e_srv, e_vrv, e_done;
        logic [15:0] e_we;
        logic [31:0] e_addr, e_ra;
        logic [127:0] e_wd;
        reset_dut();
        for (int k = 0; k < 3000 && fails < 30; k++) begin
            cyc();
            if (prev_sg) spu_req = 0;
            if (prev_vg) vga_req = 0;
            if (!spu_req && $urandom_range(3) == 0) begin
                spu_req = 1;
                spu_we = ($urandom_range(1) == 0) ? 16'h0 : 16'($urandom);
                spu_addr = $urandom;
                spu_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!vga_req && $urandom_range(5) == 0) begin
                vga_req = 1;
                vga_addr = $urandom & 32'hFFFF_FFF0;
            end
            vga_urgent = ($urandom_range(2) == 0);
            #1;
            // Expected command for this cycle from the transaction currently in flight.
            e_en = 0; e_we = '0; e_addr = '0; e_wd = '0; e_sg = 0; e_vg = 0;
            if (kind == 1 && k == start) begin
                e_en = 1; e_we = we_s; e_addr = a_s; e_wd = wd_s; e_sg = 1;
                last_vga = 0; urg = 0;
            end else if (kind == 2 && k >= start && k < start + BL) begin
                b = k - start;
                e_en = 1; e_addr = base + 32'(16 * b); e_vg = (b == 0);
                if (b == BL - 1) begin
                    last_vga = 1;
                    urg = urg_win ? ((urg < UM) ? urg + 1 : UM) : 0;
                end
            end
            if (e_en && e_we == 16'h0) begin
                due_q.push_back(k + LAT); own_q.push_back(kind == 2);
                lst_q.push_back(kind == 2 && k == start + BL - 1); ra_q.push_back(e_addr);
            end
            e_srv = 0; e_vrv = 0; e_done = 0; e_ra = '0;
            if (due_q.size() > 0 && due_q[0] == k) begin
                void'(due_q.pop_front());
                e_vrv = own_q.pop_front();
                e_srv = !e_vrv;
                e_done = lst_q.pop_front() && e_vrv;
                e_ra = ra_q.pop_front();
            end
            tests++;
            if (mem_en !== e_en || mem_we !== e_we || mem_addr !== e_addr || mem_wdata !== e_wd) begin
                fails++; $display("FAIL rnd_cmd k=%0d en/we/addr got %b/%h/%h want %b/%h/%h",
                    k, mem_en, mem_we, mem_addr, e_en, e_we, e_addr);
            end
            tests++;
            if (spu_gnt !== e_sg || vga_gnt !== e_vg) begin
                fails++; $display("FAIL rnd_gnt k=%0d sg/vg got %b/%b want %b/%b", k, spu_gnt, vga_gnt, e_sg, e_vg);
            end
            tests++;
            if (spu_rvalid !== e_srv || vga_rvalid !== e_vrv || vga_done !== e_done) begin
                fails++; $display("FAIL rnd_ret k=%0d srv/vrv/done got %b/%b/%b want %b/%b/%b",
                    k, spu_rvalid, vga_rvalid, vga_done, e_srv, e_vrv, e_done);
            end
            if (e_srv || e_vrv) begin
                tests++;
                if ((e_srv ? spu_rdata : vga_rdata) !== fdata(e_ra)) begin
                    fails++; $display("FAIL rnd_rdata k=%0d got %h want %h", k,
                        (e_srv ? spu_rdata : vga_rdata), fdata(e_ra));
                end
            end
            // Arbitration decision whenever the port is free.
            if (k >= busy_until) begin
                kind = 0; urg_win = 0;
                if (vga_req && vga_urgent && !(spu_req && urg == UM)) begin
                    kind = 2; urg_win = spu_req;
                end else if (spu_req && vga_req) kind = last_vga ? 1 : 2;
                else if (spu_req) kind = 1;
                else if (vga_req) kind = 2;
                if (kind == 1) begin
                    we_s = spu_we; a_s = spu_addr; wd_s = spu_wdata;
                    start = k + 1; busy_until = k + 2;
                end
                if (kind == 2) begin
                    base = vga_addr; start = k + 1; busy_until = k + 1 + BL;
                end
            end
            prev_sg = e_sg; prev_vg = e_vg;
        end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_spu_read();
        test_vga_burst();
        test_wrap();
        test_alternate();
        test_urgent();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the 128-bit data-memory port B between two requesters:
  - SPU single-beat loads/stores.
  - VGA framebuffer fetcher, which issues fixed-length read bursts.
- Sits between the SPU/VGA fetch logic and the main data memory's port B.
- Round-robin arbitration with an urgent override for VGA and a starvation guard for SPU.
- Tracks read latency so returned data is steered to the correct requester.

Parameters:
- BURST_LEN, 8: beats per VGA burst (1..16).
- MEM_LAT, 1: memory read latency in cycles, from mem_en to valid mem_rdata (1..4).
- URGENT_MAX, 4: consecutive urgent VGA wins allowed while spu_req is pending.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- spu_req  in  1  SPU request; held until spu_gnt
- spu_we  in  16  byte write enables; 0 = read
- spu_addr  in  32  SPU byte address
- spu_wdata  in  128  SPU write data
- spu_gnt  out  1  one-cycle pulse when the SPU command is issued to memory
- spu_rvalid  out  1  SPU read data valid
- spu_rdata  out  128  SPU read data
- vga_req  in  1  burst request; held until vga_gnt
- vga_urgent  in  1  fetch FIFO low; raises VGA priority
- vga_addr  in  32  burst base byte address
- vga_gnt  out  1  one-cycle pulse on the first beat of a burst
- vga_rvalid  out  1  VGA read beat valid
- vga_rdata  out  128  VGA read data
- vga_done  out  1  one-cycle pulse with the last burst beat's rvalid
- mem_en  out  1  memory command strobe
- mem_we  out  16  memory byte write enables
- mem_addr  out  32  memory address
- mem_wdata  out  128  memory write data
- mem_rdata  in  128  memory read data

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state:
  - State = IDLE; last_owner = VGA, so SPU wins the first tie; beat counter, urgent counter and return-tag pipeline cleared.
  - All outputs 0, except spu_rdata/vga_rdata, which pass mem_rdata through and are meaningful only when the matching rvalid is high.
- States: IDLE, SPU, VGA.
- IDLE decision, registered into the next state:
  - Winner is chosen in this order:
    1. If vga_req && vga_urgent && !(spu_req && urg_cnt == URGENT_MAX), VGA wins.
    2. Else if both requests are pending, the requester other than last_owner wins.
    3. Else the single requester wins.
  - No requests: stay in IDLE.
- SPU state, one cycle:
  - Drive mem_en=1, mem_we=spu_we, mem_addr=spu_addr, mem_wdata=spu_wdata; spu_gnt=1.
  - Set last_owner=SPU; clear urg_cnt; next state IDLE.
- VGA state, BURST_LEN cycles:
  - Drive mem_en=1, mem_we=0, mem_addr = vga_addr_latched + 16*beat, wrapping modulo 2^32.
  - vga_addr is latched at the IDLE decision.
  - vga_gnt=1 on beat 0 only.
  - Burst is non-interruptible.
- VGA burst end:
  - Set last_owner=VGA; next state IDLE.
  - If the win was via the urgent rule while spu_req was high, increment urg_cnt (saturating at URGENT_MAX); otherwise clear it.
- Idle outputs: mem_en=0 and mem_* = 0 whenever no command is issued.
- Return steering:
  - A MEM_LAT-deep tag pipeline carries {valid_read, owner, last_beat}, pushed every cycle; a read is mem_en && mem_we==0.
  - At the pipeline output, spu_rvalid or vga_rvalid = valid_read && owner matches.
  - vga_done = vga_rvalid && last_beat.
- Writes: an SPU write produces spu_gnt only, no rvalid.
- Throughput: an SPU op occupies 2 cycles (decision + issue). A VGA burst occupies BURST_LEN+1 cycles.
- Simultaneous events:
  - A request that deasserts before its grant is a protocol violation; there is no required behaviour.
  - Requests arriving while non-IDLE wait for IDLE.
- Reset mid-burst or with reads outstanding: everything aborts immediately and pending rvalids are dropped, never emitted after reset release.

Test Plan:
- SPU read alone, MEM_LAT=1, spu_addr=0x0080_0010: decision in cycle 0; cycle 1 mem_en=1, mem_addr=0x0080_0010, spu_gnt=1; cycle 2 spu_rvalid=1, spu_rdata=mem_rdata.
- VGA burst alone, BURST_LEN=8, vga_addr=0x0090_0000: mem_addr steps 0x0090_0000..0x0090_0070 over 8 consecutive cycles; vga_gnt on the first beat only; 8 vga_rvalid beats; vga_done coincides with the 8th.
- Both requesting, vga_urgent=0, from reset: SPU issued first, then the VGA burst, then SPU again if it re-requests (alternation).
- vga_urgent=1 held with spu_req held (URGENT_MAX=4): four VGA bursts, then one SPU op, then VGA resumes; spu_gnt count=1 after the 5th IDLE decision.
- Burst base 0xFFFF_FFF0, BURST_LEN=2: addresses 0xFFFF_FFF0 then 0x0000_0000.
- rst_n low on beat 3 of a burst, MEM_LAT=2: all outputs 0 immediately; no vga_rvalid/vga_done after release; next request is arbitrated normally, SPU first.
